// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle big-endian data memory with valid/ready request and one-cycle response pulse.
// Optional accepted-request counter output acc_cnt enabled by defining DMEM_ACC_CNT_EN.
module dmem_responder #(
   parameter int ADDR_W      = 9,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] A,
   input  logic [31:0]       DI,
   input  logic [1:0]        Size,
   input  logic              RW,
   input  logic              SE,
   output logic              rsp_valid,
   output logic [31:0]       DO,
   output logic              err
`ifdef DMEM_ACC_CNT_EN
   ,output logic [15:0]      acc_cnt
`endif
);
   localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
   logic [1:0]        state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] a_q, fa, a1, a2, a3;
   logic [31:0]       di_q, fdi, ld;
   logic [1:0]        size_q, fsize;
   logic              rw_q, se_q, frw, fse, bad, accept, go;
   logic [7:0]        b0, b1, b2, b3;
   logic [7:0]        mem [0:(1<<ADDR_W)-1];

   assign req_ready = state == IDLE;
   assign rsp_valid = state == RESP;
   assign accept    = reset && state == IDLE && req_valid;
   assign go        = (accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
   // With no wait states the access happens on the acceptance edge, so use the live inputs.
   assign fa    = state == IDLE ? A    : a_q;
   assign fdi   = state == IDLE ? DI   : di_q;
   assign fsize = state == IDLE ? Size : size_q;
   assign frw   = state == IDLE ? RW   : rw_q;
   assign fse   = state == IDLE ? SE   : se_q;
   assign a1    = fa + ADDR_W'(1);
   assign a2    = fa + ADDR_W'(2);
   assign a3    = fa + ADDR_W'(3);
   assign bad   = fsize == 2'b11 || (fsize == 2'b01 && fa[0]) || (fsize == 2'b10 && fa[1:0] != 2'b00);
   assign b0    = mem[fa];
   assign b1    = mem[a1];
   assign b2    = mem[a2];
   assign b3    = mem[a3];
   assign ld    = fsize == 2'b00 ? {{24{fse & b0[7]}}, b0} :
                  fsize == 2'b01 ? {{16{fse & b0[7]}}, b0, b1} : {b0, b1, b2, b3};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         a_q    <= '0;
         di_q   <= 32'd0;
         size_q <= 2'd0;
         rw_q   <= 1'b0;
         se_q   <= 1'b0;
         DO     <= 32'd0;
         err    <= 1'b0;
      end else begin
         DO  <= (go && !frw && !bad) ? ld : 32'd0;
         err <= go && bad;
         case (state)
            IDLE: if (req_valid) begin
               a_q    <= A;
               di_q   <= DI;
               size_q <= Size;
               rw_q   <= RW;
               se_q   <= SE;
               cnt    <= 4'(WAIT_CYCLES - 1);
               state  <= WAIT_CYCLES == 0 ? RESP : WAIT;
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd0) state <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (go && frw && !bad) begin
         if (fsize == 2'b00) mem[fa] <= fdi[7:0];
         else if (fsize == 2'b01) begin
            mem[fa] <= fdi[15:8];
            mem[a1] <= fdi[7:0];
         end else begin
            mem[fa] <= fdi[31:24];
            mem[a1] <= fdi[23:16];
            mem[a2] <= fdi[15:8];
            mem[a3] <= fdi[7:0];
         end
      end
   end

`ifdef DMEM_ACC_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) acc_cnt <= 16'd0;
      else if (accept && acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven checks of dmem_responder (WAIT_CYCLES=2) plus reset and zero-wait sequences.
module tb_dmem_responder;
   typedef struct {
      logic [8:0]  a;
      logic [31:0] di;
      logic [1:0]  size;
      logic        rw;
      logic        se;
      logic [31:0] exp_do;
      logic        exp_err;
   } vec_t;

   logic        clk = 1'b0, reset = 1'b0;
   logic        req_valid = 1'b0, RW = 1'b0, SE = 1'b0;
   logic [8:0]  A = '0;
   logic [31:0] DI = '0;
   logic [1:0]  Size = '0;
   logic        req_ready, rsp_valid, err;
   logic [31:0] DO;
   logic        rv0 = 1'b0, RW0 = 1'b0, SE0 = 1'b0;
   logic [8:0]  A0 = '0;
   logic [31:0] DI0 = '0;
   logic [1:0]  Size0 = '0;
   logic        ready0, rsp0, err0;
   logic [31:0] DO0;
   int          tests = 0, fails = 0, nreq = 0;
`ifdef DMEM_ACC_CNT_EN
   logic [15:0] acc_cnt, acc_cnt0;
`endif

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .A(A), .DI(DI), .Size(Size), .RW(RW), .SE(SE),
      .rsp_valid(rsp_valid), .DO(DO), .err(err)
`ifdef DMEM_ACC_CNT_EN
      , .acc_cnt(acc_cnt)
`endif
   );

   dmem_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .req_valid(rv0), .req_ready(ready0),
      .A(A0), .DI(DI0), .Size(Size0), .RW(RW0), .SE(SE0),
      .rsp_valid(rsp0), .DO(DO0), .err(err0)
`ifdef DMEM_ACC_CNT_EN
      , .acc_cnt(acc_cnt0)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run(input vec_t v, input int idx);
      int lat;
      lat = 0;
      @(negedge clk);
      check($sformatf("v%0d ready", idx), req_ready, 1);
      req_valid = 1'b1; A = v.a; DI = v.di; Size = v.size; RW = v.rw; SE = v.se;
      @(posedge clk);
      #1;
      nreq++;
      req_valid = 1'b0; A = 9'($urandom); DI = $urandom; Size = 2'($urandom); SE = ~v.se;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 10);
      check($sformatf("v%0d latency", idx), lat, 3);
      check($sformatf("v%0d DO", idx), DO, v.exp_do);
      check($sformatf("v%0d err", idx), err, v.exp_err);
      @(negedge clk);
      check($sformatf("v%0d pulse", idx), rsp_valid, 0);
   endtask

   vec_t tv[18];

   initial begin
      tv[0]  = '{9'h010, 32'hDEADBEEF, 2'b10, 1'b1, 1'b0, 32'h00000000, 1'b0};
      tv[1]  = '{9'h010, 32'h0,        2'b10, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
      tv[2]  = '{9'h011, 32'h0,        2'b00, 1'b0, 1'b1, 32'hFFFFFFAD, 1'b0};
      tv[3]  = '{9'h011, 32'h0,        2'b00, 1'b0, 1'b0, 32'h000000AD, 1'b0};
      tv[4]  = '{9'h012, 32'h0,        2'b01, 1'b0, 1'b1, 32'hFFFFBEEF, 1'b0};
      tv[5]  = '{9'h010, 32'h0,        2'b01, 1'b0, 1'b0, 32'h0000DEAD, 1'b0};
      tv[6]  = '{9'h010, 32'h0,        2'b00, 1'b0, 1'b1, 32'hFFFFFFDE, 1'b0};
      tv[7]  = '{9'h013, 32'h12345655, 2'b00, 1'b1, 1'b0, 32'h00000000, 1'b0};
      tv[8]  = '{9'h010, 32'h0,        2'b10, 1'b0, 1'b0, 32'hDEADBE55, 1'b0};
      tv[9]  = '{9'h012, 32'h11111111, 2'b10, 1'b1, 1'b0, 32'h00000000, 1'b1};
      tv[10] = '{9'h010, 32'h0,        2'b10, 1'b0, 1'b0, 32'hDEADBE55, 1'b0};
      tv[11] = '{9'h010, 32'h0,        2'b11, 1'b0, 1'b0, 32'h00000000, 1'b1};
      tv[12] = '{9'h011, 32'h0,        2'b01, 1'b0, 1'b1, 32'h00000000, 1'b1};
      tv[13] = '{9'h1FE, 32'h0000A5B6, 2'b01, 1'b1, 1'b0, 32'h00000000, 1'b0};
      tv[14] = '{9'h1FE, 32'h0,        2'b01, 1'b0, 1'b0, 32'h0000A5B6, 1'b0};
      tv[15] = '{9'h1FF, 32'h0,        2'b00, 1'b0, 1'b1, 32'hFFFFFFB6, 1'b0};
      tv[16] = '{9'h020, 32'h01020304, 2'b10, 1'b1, 1'b0, 32'h00000000, 1'b0};
      tv[17] = '{9'h020, 32'h0,        2'b10, 1'b0, 1'b0, 32'h01020304, 1'b0};

      repeat (2) @(negedge clk);
      check("rst req_ready", req_ready, 1);
      check("rst rsp_valid", rsp_valid, 0);
      check("rst DO", DO, 0);
      check("rst err", err, 0);
      check("rst ready0", ready0, 1);
      reset = 1'b1;

      for (int i = 0; i < 18; i++) run(tv[i], i);
`ifdef DMEM_ACC_CNT_EN
      check("acc_cnt table", acc_cnt, 32'(nreq));
`endif

      // Reset while a store is in WAIT: no response and no commit.
      @(negedge clk);
      req_valid = 1'b1; A = 9'h020; DI = 32'hCAFEF00D; Size = 2'b10; RW = 1'b1; SE = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("wait ready", req_ready, 0);
      reset = 1'b0;
      #1;
      check("abort ready", req_ready, 1);
      check("abort rsp", rsp_valid, 0);
      repeat (2) @(negedge clk);
      check("abort no rsp", rsp_valid, 0);
      reset = 1'b1;
      nreq = 0;
      tv[17].exp_do = 32'h01020304;
      run(tv[17], 100);
`ifdef DMEM_ACC_CNT_EN
      check("acc_cnt after reset", acc_cnt, 32'(nreq));
`endif

      // Zero wait states with req_valid held high: one response every second cycle.
      @(negedge clk);
      rv0 = 1'b1; A0 = 9'h040; DI0 = 32'h89ABCDEF; Size0 = 2'b10; RW0 = 1'b1; SE0 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("w0 rsp %0d", i), rsp0, (i % 2 == 0) ? 1 : 0);
         check($sformatf("w0 ready %0d", i), ready0, (i % 2 == 1) ? 1 : 0);
`ifdef DMEM_ACC_CNT_EN
         check($sformatf("w0 acc_cnt %0d", i), acc_cnt0, 32'(i / 2 + 1));
`endif
      end
      rv0 = 1'b0;
      @(negedge clk);
      rv0 = 1'b1; RW0 = 1'b0;
      @(posedge clk);
      #1;
      rv0 = 1'b0; DI0 = 32'h0;
      @(negedge clk);
      check("w0 load rsp", rsp0, 1);
      check("w0 load DO", DO0, 32'h89ABCDEF);
      check("w0 load err", err0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
